// File: rtl/fetch_line_aligner.sv
// Buffers one I-cache line and hands its instructions to decode one per cycle,
// starting at the word addressed by the fetch pc and stopping at the end of the line.
module fetch_line_aligner #(
  parameter int LINE_INSTR = 16,
  parameter int INSTR_W    = 32,
  parameter int PC_W       = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          line_valid_i,
  output logic                          line_ready_o,
  input  logic [LINE_INSTR*INSTR_W-1:0] line_i,
  input  logic [PC_W-1:0]               line_pc_i,
  input  logic                          line_err_i,
  output logic                          instr_valid_o,
  input  logic                          instr_ready_i,
  output logic [INSTR_W-1:0]            instr_o,
  output logic [PC_W-1:0]               instr_pc_o,
  output logic                          instr_except_o,
  output logic [4:0]                    instr_except_code_o,
  output logic                          instr_last_o
);

  localparam int                 OFF_W   = $clog2(LINE_INSTR);
  localparam logic [OFF_W-1:0]   OFF_MAX = OFF_W'(LINE_INSTR - 1);
  localparam logic [INSTR_W-1:0] NOP     = INSTR_W'(32'h0000_0013);

  typedef enum logic {EMPTY, ISSUE} state_e;

  // Handshakes (both sides): a transfer happens in a cycle where valid and ready
  // are both high at the rising edge; valid, once raised, holds its payload until taken.

  state_e                               state_q, state_d;
  logic [OFF_W-1:0]                     offset_q, offset_d;
  logic [LINE_INSTR-1:0][INSTR_W-1:0]   line_q, line_d;
  logic [PC_W-1:0]                      pc_q, pc_d;
  logic                                 exc_q, exc_d;
  logic                                 fault_q, fault_d;

  logic is_issue, last, load, fire;

  always_comb begin
    is_issue            = (state_q == ISSUE);
    last                = is_issue & (exc_q | (offset_q == OFF_MAX));
    instr_valid_o       = is_issue & !flush_i;
    line_ready_o        = !flush_i & (!is_issue | (last & instr_ready_i));
    load                = line_valid_i & line_ready_o;
    fire                = instr_valid_o & instr_ready_i;

    instr_o             = NOP;
    instr_pc_o          = '0;
    instr_except_o      = 1'b0;
    instr_except_code_o = 5'd0;
    instr_last_o        = last;
    if (is_issue) begin
      if (exc_q) begin
        // An excepting line issues a single NOP entry carrying the raw fetch pc.
        instr_pc_o          = pc_q;
        instr_except_o      = 1'b1;
        instr_except_code_o = {4'd0, fault_q};
      end else begin
        instr_o    = line_q[offset_q];
        instr_pc_o = {pc_q[PC_W-1:2+OFF_W], offset_q, 2'b00};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    line_d   = line_q;
    pc_d     = pc_q;
    exc_d    = exc_q;
    fault_d  = fault_q;
    if (flush_i) begin
      state_d  = EMPTY;
      offset_d = '0;
      exc_d    = 1'b0;
      fault_d  = 1'b0;
    end else begin
      if (fire) begin
        if (last) state_d = EMPTY;
        else      offset_d = offset_q + 1'b1;
      end
      // A load in the same cycle as the last handshake overrides the return to EMPTY.
      if (load) begin
        state_d  = ISSUE;
        line_d   = line_i;
        pc_d     = line_pc_i;
        offset_d = (line_pc_i[1:0] == 2'b00) ? line_pc_i[2 +: OFF_W] : '0;
        exc_d    = line_err_i | (line_pc_i[1:0] != 2'b00);
        fault_d  = line_err_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      offset_q <= '0;
      line_q   <= '0;
      pc_q     <= '0;
      exc_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      line_q   <= line_d;
      pc_q     <= pc_d;
      exc_q    <= exc_d;
      fault_q  <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_line_aligner.sv
// Directed bench for fetch_line_aligner: aligned/partial lines, back-to-back load,
// backpressure, exceptions, flush and asynchronous reset.
module tb_fetch_line_aligner;

  localparam int LINE_INSTR = 16;
  localparam int INSTR_W    = 32;
  localparam int PC_W       = 64;

  logic                          clk_i = 1'b0;
  logic                          rst_i;
  logic                          flush_i;
  logic                          line_valid_i;
  logic                          line_ready_o;
  logic [LINE_INSTR*INSTR_W-1:0] line_i;
  logic [PC_W-1:0]               line_pc_i;
  logic                          line_err_i;
  logic                          instr_valid_o;
  logic                          instr_ready_i;
  logic [INSTR_W-1:0]            instr_o;
  logic [PC_W-1:0]               instr_pc_o;
  logic                          instr_except_o;
  logic [4:0]                    instr_except_code_o;
  logic                          instr_last_o;

  int total = 0;
  int bad   = 0;

  fetch_line_aligner #(.LINE_INSTR(LINE_INSTR), .INSTR_W(INSTR_W), .PC_W(PC_W)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .flush_i             (flush_i),
    .line_valid_i        (line_valid_i),
    .line_ready_o        (line_ready_o),
    .line_i              (line_i),
    .line_pc_i           (line_pc_i),
    .line_err_i          (line_err_i),
    .instr_valid_o       (instr_valid_o),
    .instr_ready_i       (instr_ready_i),
    .instr_o             (instr_o),
    .instr_pc_o          (instr_pc_o),
    .instr_except_o      (instr_except_o),
    .instr_except_code_o (instr_except_code_o),
    .instr_last_o        (instr_last_o)
  );

  // clock/reset
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_INSTR*INSTR_W-1:0] make_line(input logic [31:0] base);
    logic [LINE_INSTR*INSTR_W-1:0] l;
    for (int k = 0; k < LINE_INSTR; k++) l[k*INSTR_W +: INSTR_W] = base + 32'(k);
    return l;
  endfunction

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic present_line(input logic [63:0] pc, input logic [31:0] base, input logic err);
    line_valid_i = 1'b1;
    line_pc_i    = pc;
    line_i       = make_line(base);
    line_err_i   = err;
  endtask

  task automatic load_line(input string tag, input logic [63:0] pc, input logic [31:0] base,
                           input logic err);
    present_line(pc, base, err);
    #1 check_val({tag, "_lrdy"}, 64'(line_ready_o), 64'd1);
    step();
    line_valid_i = 1'b0;
  endtask

  task automatic expect_instr(input string tag, input logic [63:0] pc, input logic [31:0] ins,
                              input logic lst, input logic exc, input logic [4:0] code);
    #1;
    check_val({tag, "_vld"},  64'(instr_valid_o), 64'd1);
    check_val({tag, "_pc"},   instr_pc_o, pc);
    check_val({tag, "_ins"},  64'(instr_o), 64'(ins));
    check_val({tag, "_last"}, 64'(instr_last_o), 64'(lst));
    check_val({tag, "_exc"},  64'(instr_except_o), 64'(exc));
    check_val({tag, "_code"}, 64'(instr_except_code_o), 64'(code));
  endtask

  task automatic expect_idle(input string tag);
    #1;
    check_val({tag, "_vld"},  64'(instr_valid_o), 64'd0);
    check_val({tag, "_ins"},  64'(instr_o), 64'h13);
    check_val({tag, "_pc"},   instr_pc_o, 64'd0);
    check_val({tag, "_exc"},  64'(instr_except_o), 64'd0);
    check_val({tag, "_code"}, 64'(instr_except_code_o), 64'd0);
    check_val({tag, "_last"}, 64'(instr_last_o), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; line_valid_i = 1'b0; line_i = '0;
    line_pc_i = '0; line_err_i = 1'b0; instr_ready_i = 1'b1;
    @(negedge clk_i);
    expect_idle("rst");
    check_val("rst_lrdy", 64'(line_ready_o), 64'd1);
    step();
    rst_i = 1'b0;
    step();
    expect_idle("idle");

    // 1: aligned full line
    load_line("t1", 64'h1000, 32'h0, 1'b0);
    for (int k = 0; k < LINE_INSTR; k++) begin
      expect_instr($sformatf("t1_%0d", k), 64'h1000 + 64'(4*k), 32'(k), k == LINE_INSTR-1,
                   1'b0, 5'd0);
      step();
    end
    expect_idle("t1_end");

    // 2: start at offset 14, back-to-back next line on the last handshake
    load_line("t2", 64'h1038, 32'h100, 1'b0);
    expect_instr("t2_a", 64'h1038, 32'h10E, 1'b0, 1'b0, 5'd0);
    step();
    present_line(64'h2000, 32'h200, 1'b0);
    expect_instr("t2_b", 64'h103C, 32'h10F, 1'b1, 1'b0, 5'd0);
    check_val("t2_b2b_lrdy", 64'(line_ready_o), 64'd1);
    step();

    // 3: backpressure 1,0,0,1; a line offered mid-line must be ignored
    present_line(64'h6000, 32'h600, 1'b0);
    expect_instr("t3_0", 64'h2000, 32'h200, 1'b0, 1'b0, 5'd0);
    check_val("t3_lrdy_mid", 64'(line_ready_o), 64'd0);
    step();
    instr_ready_i = 1'b0;
    expect_instr("t3_h1", 64'h2004, 32'h201, 1'b0, 1'b0, 5'd0);
    step();
    expect_instr("t3_h2", 64'h2004, 32'h201, 1'b0, 1'b0, 5'd0);
    step();
    instr_ready_i = 1'b1;
    line_valid_i  = 1'b0;
    expect_instr("t3_1", 64'h2004, 32'h201, 1'b0, 1'b0, 5'd0);
    step();
    for (int k = 2; k < 5; k++) begin
      expect_instr($sformatf("t3_%0d", k), 64'h2000 + 64'(4*k), 32'h200 + 32'(k), 1'b0,
                   1'b0, 5'd0);
      step();
    end

    // 6: flush at offset 5 with a line offered in the same cycle
    expect_instr("t6_pre", 64'h2014, 32'h205, 1'b0, 1'b0, 5'd0);
    flush_i = 1'b1;
    present_line(64'h5004, 32'h500, 1'b0);
    #1;
    check_val("t6_flush_vld",  64'(instr_valid_o), 64'd0);
    check_val("t6_flush_lrdy", 64'(line_ready_o), 64'd0);
    step();
    flush_i = 1'b0;
    line_valid_i = 1'b0;
    #1 check_val("t6_empty_vld", 64'(instr_valid_o), 64'd0);
    check_val("t6_empty_lrdy", 64'(line_ready_o), 64'd1);
    @(negedge clk_i);
    load_line("t6_new", 64'h5004, 32'h500, 1'b0);
    expect_instr("t6_n0", 64'h5004, 32'h501, 1'b0, 1'b0, 5'd0);
    step();
    expect_instr("t6_n1", 64'h5008, 32'h502, 1'b0, 1'b0, 5'd0);
    rst_i = 1'b1;
    expect_idle("t6_rst");
    step();
    rst_i = 1'b0;
    step();
    expect_idle("t6_post_rst");

    // 4: access fault
    load_line("t4", 64'h3008, 32'h300, 1'b1);
    expect_instr("t4", 64'h3008, 32'h13, 1'b1, 1'b1, 5'h01);
    step();
    expect_idle("t4_end");

    // 5: misaligned pc, then misaligned plus fault
    load_line("t5a", 64'h4002, 32'h400, 1'b0);
    expect_instr("t5a", 64'h4002, 32'h13, 1'b1, 1'b1, 5'h00);
    step();
    expect_idle("t5a_end");
    load_line("t5b", 64'h4002, 32'h400, 1'b1);
    expect_instr("t5b", 64'h4002, 32'h13, 1'b1, 1'b1, 5'h01);
    step();
    expect_idle("t5b_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
